ifetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle-control MIPS core. Holds the PC, reads the instruction block RAM, and presents a stable registered instruction whose opcode/funct feed the Controller. Consumes the Controller's Jr/Jmp/Jal/Branch/nBranch, the ALU Zero flag and the rs value to compute the next PC. Runs a 3-state fetch FSM so every downstream write is gated by a single commit strobe.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/npc_calc.sv | 37 +++
 rtl/ifetch_unit.sv | 111 +++++++++++
 tb/tb_ifetch_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: state encoding, reset/geometry
// defaults and the jump/branch opcodes the Controller decodes.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_EXEC  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
    localparam int          IMEM_AW_DEF  = 14;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection: jr, then j/jal, then taken branch, else sequential.
// Purely combinational; all arithmetic wraps modulo 2^32.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] jidx,
    input  logic        jr,
    input  logic        jmp,
    input  logic        jal,
    input  logic        branch,
    input  logic        nbranch,
    input  logic        zero,
    input  logic [31:0] rs_val,
    input  logic [31:0] imm,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] br_target;
    logic        br_taken;

    // Priority mux; the order matters when the Controller asserts several.
    always_comb begin
        pc_plus4  = pc + 32'd4;
        br_target = pc_plus4 + {imm[29:0], 2'b00};
        br_taken  = (branch && zero) || (nbranch && !zero);
        next_pc   = pc_plus4;
        if (jr)
            next_pc = word_align(rs_val);
        else if (jmp || jal)
            next_pc = {pc_plus4[31:28], jidx, 2'b00};
        else if (br_taken)
            next_pc = br_target;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, instruction register, retired counter and a
// three-state FETCH/LOAD/EXEC sequencer whose EXEC exit is the commit strobe.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IMEM_AW  = IMEM_AW_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               Jr,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Zero,
    input  logic [31:0]        Read_data_1,
    input  logic [31:0]        Imm_extend,
    input  logic               hold,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        Instruction,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        link_addr,
    output logic [31:0]        instr_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;

    npc_calc u_npc (
        .pc       (pc_q),
        .jidx     (ir_q[25:0]),
        .jr       (Jr),
        .jmp      (Jmp),
        .jal      (Jal),
        .branch   (Branch),
        .nbranch  (nBranch),
        .zero     (Zero),
        .rs_val   (Read_data_1),
        .imm      (Imm_extend),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    // Sequencer: fetch, capture IR, then commit unless stalled by hold.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        imem_en     = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_en = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                ir_d    = imem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!hold) begin
                    instr_valid = 1'b1;
                    pc_d        = next_pc;
                    cnt_d       = cnt_q + 32'd1;
                    state_d     = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        // Nothing escapes while reset is held, even before the first edge.
        if (reset) begin
            imem_en     = 1'b0;
            instr_valid = 1'b0;
        end
    end

    // State registers; reset aborts any in-flight instruction without commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign Instruction = reset ? 32'd0 : ir_q;
    assign opcode      = Instruction[31:26];
    assign funct       = Instruction[5:0];
    assign pc          = pc_q;
    assign link_addr   = reset ? (PC_RESET + 32'd4) : pc_plus4;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: the bench plays Controller and instruction
// RAM, and a queue holds the pc expected at each upcoming commit.
module tb_ifetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        Jr, Jmp, Jal, Branch, nBranch, Zero, hold;
    logic [31:0] Read_data_1, Imm_extend;
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] Instruction;
    logic [5:0]  opcode, funct;
    logic        instr_valid;
    logic [31:0] pc, link_addr, instr_count;

    logic [31:0] mem [0:16383];
    logic [31:0] exp_q [$];
    logic [31:0] exp_cnt;
    int          tests = 0;
    int          fails = 0;

    ifetch_unit #(.PC_RESET(32'h0), .IMEM_AW(14)) dut (
        .clock(clock), .reset(reset), .Jr(Jr), .Jmp(Jmp), .Jal(Jal),
        .Branch(Branch), .nBranch(nBranch), .Zero(Zero),
        .Read_data_1(Read_data_1), .Imm_extend(Imm_extend), .hold(hold),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .Instruction(Instruction), .opcode(opcode), .funct(funct),
        .instr_valid(instr_valid), .pc(pc), .link_addr(link_addr),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    // Synchronous-read instruction RAM.
    always @(posedge clock) if (imem_en) imem_rdata <= mem[imem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_ctrl();
        Jr = 0; Jmp = 0; Jal = 0; Branch = 0; nBranch = 0; Zero = 0;
        Read_data_1 = 32'd0; Imm_extend = 32'd0;
    endtask

    // Wait for the commit, check it, drive controls, push the next expected pc.
    task automatic commit(input string tag, input logic [31:0] exp_ir,
                          input logic jr, input logic jmp, input logic jal,
                          input logic br, input logic nbr, input logic z,
                          input logic [31:0] rs, input logic [31:0] imm,
                          input logic [31:0] nxt, input int nhold);
        int n = 0;
        logic [31:0] e;
        while (!instr_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'd2);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk({tag, "_pc"}, pc, e);
        chk({tag, "_ir"}, Instruction, exp_ir);
        chk({tag, "_opcode"}, 32'(opcode), 32'(exp_ir[31:26]));
        chk({tag, "_link"}, link_addr, e + 32'd4);
        chk({tag, "_count_pre"}, instr_count, exp_cnt);
        if (nhold > 0) begin
            hold = 1'b1;
            #1;
            chk({tag, "_held_valid"}, 32'(instr_valid), 32'd0);
            for (int k = 1; k < nhold; k++) begin
                @(posedge clock);
                @(negedge clock);
                chk({tag, "_held_valid"}, 32'(instr_valid), 32'd0);
                chk({tag, "_held_pc"}, pc, e);
                chk({tag, "_held_count"}, instr_count, exp_cnt);
            end
            hold = 1'b0;
            #1;
            chk({tag, "_release_valid"}, 32'(instr_valid), 32'd1);
        end
        Jr = jr; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr; Zero = z;
        Read_data_1 = rs; Imm_extend = imm;
        exp_q.push_back(nxt);
        exp_cnt = exp_cnt + 32'd1;
        @(posedge clock);
        @(negedge clock);
        clr_ctrl();
        chk({tag, "_valid_off"}, 32'(instr_valid), 32'd0);
        chk({tag, "_count"}, instr_count, exp_cnt);
        chk({tag, "_next_pc"}, pc, nxt);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        mem[0]       = 32'h0000_0020;  // add
        mem[1]       = 32'h0000_0021;
        mem[2]       = 32'h0000_0022;
        mem[3]       = 32'h0800_0008;  // j 0x20
        mem[4]       = 32'h0C00_0040;  // jal 0x100
        mem[8]       = 32'h1000_FFFF;  // beq -1
        mem[9]       = 32'h03E0_0008;  // jr
        mem[13]      = 32'h0280_0008;  // jr
        mem[16'h40]  = 32'h0800_0040;  // j 0x100
        mem[16'h80]  = 32'h0800_0004;  // j 0x10
        mem[14'h3FFF] = 32'h0000_0025;
        clr_ctrl();
        hold = 1'b0;
        reset = 1'b1;
        exp_cnt = 32'd0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_ir", Instruction, 32'd0);
        chk("rst_opfn", {20'd0, opcode, funct}, 32'd0);
        chk("rst_link", link_addr, 32'd4);
        chk("rst_pc", pc, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        reset = 1'b0;
        exp_q.push_back(32'h0);

        // Sequential stream, CPI 3.
        commit("seq0", 32'h0000_0020, 0,0,0,0,0,0, 0, 0, 32'h4, 0);
        commit("seq1", 32'h0000_0021, 0,0,0,0,0,0, 0, 0, 32'h8, 0);
        commit("seq2", 32'h0000_0022, 0,0,0,0,0,0, 0, 0, 32'hC, 0);
        chk("seq_count3", instr_count, 32'd3);
        commit("j20", 32'h0800_0008, 0,1,0,0,0,0, 0, 0, 32'h20, 0);
        // Branches.
        commit("beq_t", 32'h1000_FFFF, 0,0,0,1,0,1, 0, 32'hFFFF_FFFF, 32'h20, 0);
        commit("beq_nt", 32'h1000_FFFF, 0,0,0,1,0,0, 0, 32'hFFFF_FFFF, 32'h24, 0);
        mem[8] = 32'h1400_0004;  // becomes bne +4 for the next visit
        // Jr beats Jmp, low bits masked.
        commit("jr_pri", 32'h03E0_0008, 1,1,0,0,0,0, 32'h203, 0, 32'h200, 0);
        commit("j10", 32'h0800_0004, 0,1,0,0,0,0, 0, 0, 32'h10, 0);
        commit("jal", 32'h0C00_0040, 0,0,1,0,0,0, 0, 0, 32'h100, 0);
        commit("j100", 32'h0800_0040, 0,1,0,0,0,0, 0, 0, 32'h100, 0);
        mem[16'h40] = 32'h0800_0008;
        // Two held cycles, then a single commit.
        commit("hold", 32'h0800_0008, 0,1,0,0,0,0, 0, 0, 32'h20, 2);
        commit("bne_t", 32'h1400_0004, 0,0,0,0,1,0, 0, 32'h4, 32'h34, 0);
        commit("jr40", 32'h0280_0008, 1,0,0,0,0,0, 32'h40, 0, 32'h40, 0);

        // Reset during S_LOAD aborts the instruction at 0x40.
        chk("abort_pc_before", pc, 32'h40);
        chk("abort_fetch_en", 32'(imem_en), 32'd1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort_pc", pc, 32'h0);
        chk("abort_ir", Instruction, 32'd0);
        chk("abort_count", instr_count, 32'd0);
        chk("abort_valid", 32'(instr_valid), 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk("abort_valid2", 32'(instr_valid), 32'd0);
        reset = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(32'h0);
        exp_cnt = 32'd0;

        // PC wrap at the top of the address space.
        commit("to_top", 32'h0000_0020, 1,0,0,0,0,0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 0);
        commit("wrap", 32'h0000_0025, 0,0,0,0,0,0, 0, 0, 32'h0, 0);
        commit("after_wrap", 32'h0000_0020, 0,0,0,0,0,0, 0, 0, 32'h4, 0);
        chk("final_count", instr_count, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
